// File: rtl/alu_types.sv
// Shared ALU types and helpers for the arbitrated ALU.
package alu_types;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2
    } operation_t;

    // Width of a requester index; at least one bit so the index always exists.
    function automatic int unsigned req_idx_w(input int unsigned num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/alu.sv
// Two-stage ALU: operand capture stage, then registered result (zero when idle).
module alu
    import alu_types::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  operation_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   out
);

    logic             s1_valid;
    operation_t       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [WIDTH:0]   result;

    // Stage 1: capture the issued operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            s1_valid <= in_valid;
            s1_op    <= op;
            s1_a     <= a;
            s1_b     <= b;
        end
    end

    // Result arithmetic, all truncated to WIDTH+1 bits; unknown opcodes yield 0.
    always_comb begin
        result = '0;
        case (s1_op)
            OP_ADD:  result = (WIDTH+1)'(s1_a) + (WIDTH+1)'(s1_b);
            OP_SUB:  result = (WIDTH+1)'(s1_a) - (WIDTH+1)'(s1_b);
            OP_MUL:  result = (WIDTH+1)'(s1_a) * (WIDTH+1)'(s1_b);
            default: result = '0;
        endcase
    end

    // Stage 2: registered result, forced to zero when nothing is in stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= s1_valid ? result : '0;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU among NUM_REQ requesters.
module alu_arbiter
    import alu_types::*;
#(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  operation_t               req_op [NUM_REQ],
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [WIDTH:0]           rsp_data,
    output logic                     idle
);

    localparam int unsigned            REQ_IDX_W   = req_idx_w(NUM_REQ);
    localparam logic [REQ_IDX_W:0]     NUM_REQ_EXT = (REQ_IDX_W+1)'(NUM_REQ);
    localparam logic [REQ_IDX_W-1:0]   LAST_IDX    = REQ_IDX_W'(NUM_REQ - 1);

    logic [WIDTH-1:0]     a_arr [NUM_REQ];
    logic [WIDTH-1:0]     b_arr [NUM_REQ];
    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [REQ_IDX_W:0]   cand;
    logic                 grant_found;
    logic [REQ_IDX_W-1:0] grant_idx;
    logic                 alu_valid;
    operation_t           alu_op;
    logic [WIDTH-1:0]     alu_a;
    logic [WIDTH-1:0]     alu_b;
    logic                 alu_rst;
    logic                 t1_valid;
    logic [REQ_IDX_W-1:0] t1_idx;

    // Split the flat operand buses into per-requester slices.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Round-robin search from rr_ptr; nothing is granted while disabled or in reset.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        req_ready   = '0;
        cand        = '0;
        if (enable && rst_n) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, rr_ptr} + (REQ_IDX_W+1)'(k);
                if (cand >= NUM_REQ_EXT) begin
                    cand = cand - NUM_REQ_EXT;
                end
                if (!grant_found && req_valid[cand[REQ_IDX_W-1:0]]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand[REQ_IDX_W-1:0];
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Steer the winner's operation into the ALU; zeros when nothing transfers.
    always_comb begin
        alu_valid = grant_found;
        alu_op    = OP_ADD;
        alu_a     = '0;
        alu_b     = '0;
        if (grant_found) begin
            alu_op = req_op[grant_idx];
            alu_a  = a_arr[grant_idx];
            alu_b  = b_arr[grant_idx];
        end
    end

    // Pointer moves past the winner after each transfer, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_found) begin
            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + REQ_IDX_W'(1);
        end
    end

    // Tag pipeline tracking the issuer; the second stage is the one-hot response strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1_valid  <= 1'b0;
            t1_idx    <= '0;
            rsp_valid <= '0;
        end else begin
            t1_valid  <= grant_found;
            t1_idx    <= grant_idx;
            rsp_valid <= '0;
            if (t1_valid) begin
                rsp_valid[t1_idx] <= 1'b1;
            end
        end
    end

    assign idle    = ~t1_valid & ~(|rsp_valid) & ~grant_found;
    assign alu_rst = ~rst_n;

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .clk     (clk),
        .rst     (alu_rst),
        .in_valid(alu_valid),
        .op      (alu_op),
        .a       (alu_a),
        .b       (alu_b),
        .out     (rsp_data)
    );

endmodule
